// File: rtl/rx_frame_checker.sv
// rx_frame_checker
// Framing and integrity stage between the UART receiver and serial_to_parallel.
// Hunts for a SYNC byte, takes a length byte, buffers the payload and checks an
// 8-bit additive checksum over LEN and payload. Only a frame whose checksum
// matches is replayed downstream, as a paced byte stream with GAP cycles
// between pulses. A rejected frame produces a frame_err pulse and updates the
// sticky err_code, and none of its bytes are ever presented on out_valid.
module rx_frame_checker #(
    parameter int         MAX_BYTES   = 32,
    parameter int         LOG_MAX     = 5,
    parameter logic [7:0] SYNC        = 8'hA5,
    parameter int         TIMEOUT_CYC = 37500,
    parameter int         TO_BITS     = 16,
    parameter int         GAP         = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    input  logic       rx_error,
    output logic       out_valid,
    output logic [7:0] out_byte,
    output logic       frame_done,
    output logic       frame_err,
    output logic [2:0] err_code,
    output logic       busy
);

    // Length and index registers need one extra bit so they can hold MAX_BYTES itself.
    localparam int                 IW       = LOG_MAX + 1;
    localparam int                 GW       = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [7:0]         MAX_LEN  = 8'(MAX_BYTES);
    localparam logic [TO_BITS-1:0] TO_LAST  = TO_BITS'(TIMEOUT_CYC - 1);
    localparam logic [GW-1:0]      GAP_LAST = GW'(GAP - 1);

    localparam logic [2:0] E_BAD_LEN  = 3'd1;
    localparam logic [2:0] E_TIMEOUT  = 3'd2;
    localparam logic [2:0] E_BAD_CSUM = 3'd3;
    localparam logic [2:0] E_LINE     = 3'd4;
    localparam logic [2:0] E_OVERRUN  = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_PAYLOAD,
        S_CSUM,
        S_RELEASE
    } state_t;

    state_t             state;
    logic [IW-1:0]      len;
    logic [IW-1:0]      wr_idx;
    logic [IW-1:0]      rd_idx;
    logic [7:0]         sum;
    logic [TO_BITS-1:0] to_cnt;
    logic [GW-1:0]      gap_cnt;
    logic [7:0]         mem [MAX_BYTES];

    // A byte that arrives together with a line error is never trusted.
    logic acc;
    logic wr_en;
    logic to_hit;

    assign acc    = rx_valid && !rx_error;
    assign wr_en  = (state == S_PAYLOAD) && acc;
    assign to_hit = (to_cnt == TO_LAST);
    assign busy   = (state != S_IDLE);

    // Payload buffer; contents survive reset, only the indices are cleared.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx[LOG_MAX-1:0]] <= rx_byte;
        end
    end

    // Frame FSM: hunting, length, payload capture, checksum compare, paced release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            len        <= '0;
            wr_idx     <= '0;
            rd_idx     <= '0;
            sum        <= '0;
            to_cnt     <= '0;
            gap_cnt    <= '0;
            out_valid  <= 1'b0;
            out_byte   <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            err_code   <= '0;
        end else begin
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;

            case (state)
                S_IDLE: begin
                    // Anything other than SYNC is line noise between frames.
                    if (acc && rx_byte == SYNC) begin
                        state  <= S_LEN;
                        to_cnt <= '0;
                    end
                end

                S_LEN, S_PAYLOAD, S_CSUM: begin
                    if (rx_error) begin
                        frame_err <= 1'b1;
                        err_code  <= E_LINE;
                        state     <= S_IDLE;
                    end else if (!acc) begin
                        // Inter-byte watchdog; a byte on the limit cycle still counts.
                        if (to_hit) begin
                            frame_err <= 1'b1;
                            err_code  <= E_TIMEOUT;
                            state     <= S_IDLE;
                        end else begin
                            to_cnt <= to_cnt + TO_BITS'(1);
                        end
                    end else begin
                        to_cnt <= '0;
                        if (state == S_LEN) begin
                            if (rx_byte == 8'd0 || rx_byte > MAX_LEN) begin
                                frame_err <= 1'b1;
                                err_code  <= E_BAD_LEN;
                                state     <= S_IDLE;
                            end else begin
                                len    <= rx_byte[IW-1:0];
                                sum    <= rx_byte;
                                wr_idx <= '0;
                                state  <= S_PAYLOAD;
                            end
                        end else if (state == S_PAYLOAD) begin
                            wr_idx <= wr_idx + IW'(1);
                            sum    <= sum + rx_byte;
                            if (wr_idx + IW'(1) == len) begin
                                state <= S_CSUM;
                            end
                        end else begin
                            if (rx_byte == sum) begin
                                // First byte goes out immediately; the rest are paced.
                                state     <= S_RELEASE;
                                out_valid <= 1'b1;
                                out_byte  <= mem[0];
                                rd_idx    <= IW'(1);
                                gap_cnt   <= '0;
                            end else begin
                                frame_err <= 1'b1;
                                err_code  <= E_BAD_CSUM;
                                state     <= S_IDLE;
                            end
                        end
                    end
                end

                S_RELEASE: begin
                    // The upstream has no flow control, so a byte here is lost.
                    if (acc) begin
                        frame_err <= 1'b1;
                        err_code  <= E_OVERRUN;
                    end
                    if (rd_idx == len) begin
                        frame_done <= 1'b1;
                        state      <= S_IDLE;
                    end else if (gap_cnt == GAP_LAST) begin
                        out_valid <= 1'b1;
                        out_byte  <= mem[rd_idx[LOG_MAX-1:0]];
                        rd_idx    <= rd_idx + IW'(1);
                        gap_cnt   <= '0;
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rx_frame_checker.sv
// tb_rx_frame_checker
// Directed scenarios plus randomized frames. Expected release bytes, timing and
// error codes come from the framing rules: checksum = (LEN + payload) mod 256,
// pulse k at checksum_cycle + 1 + GAP*k, frame_done one cycle after the last.
// Cycle numbers: a byte driven in cycle n is sampled at the edge ending cycle n;
// a registered reaction to it is visible in cycle n+1.
module tb_rx_frame_checker;

    localparam int MAXB = 32;
    localparam int TO   = 300;
    localparam int GAPC = 3;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       rx_valid = 1'b0;
    logic       rx_error = 1'b0;
    logic [7:0] rx_byte  = 8'h00;
    logic       out_valid, frame_done, frame_err, busy;
    logic [7:0] out_byte;
    logic [2:0] err_code;

    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    int         tx_cyc = 0;
    logic [2:0] exp_code = 3'd0;

    int         ov_cyc[$];
    logic [7:0] ov_byte[$];
    int         done_cyc[$];
    int         err_cyc[$];

    rx_frame_checker #(
        .MAX_BYTES(MAXB), .LOG_MAX(5), .SYNC(8'hA5),
        .TIMEOUT_CYC(TO), .TO_BITS(16), .GAP(GAPC)
    ) dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_byte(rx_byte),
        .rx_error(rx_error), .out_valid(out_valid), .out_byte(out_byte),
        .frame_done(frame_done), .frame_err(frame_err), .err_code(err_code),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (out_valid) begin
            ov_cyc.push_back(cyc);
            ov_byte.push_back(out_byte);
        end
        if (frame_done) done_cyc.push_back(cyc);
        if (frame_err)  err_cyc.push_back(cyc);
    end

    function automatic logic [7:0] csum_of(input int len, input logic [7:0] pl[$]);
        int s;
        s = len;
        foreach (pl[k]) s += int'(pl[k]);
        return 8'(s % 256);
    endfunction

    // Called at a negedge; presents one byte for exactly one cycle.
    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        tx_cyc   = cyc;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_mon();
        ov_cyc.delete();
        ov_byte.delete();
        done_cyc.delete();
        err_cyc.delete();
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (out_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++; if (out_byte !== 8'h00)  begin n_fail++; $display("FAIL reset_out_byte: got %h want 00", out_byte); end
        n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
        n_checks++; if (frame_err !== 1'b0)  begin n_fail++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
        n_checks++; if (err_code !== 3'd0)   begin n_fail++; $display("FAIL reset_err_code: got %0d want 0", err_code); end
        n_checks++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst = 1'b1;
        idle(2);
        clear_mon();
    endtask

    // A5 03 11 22 33 69: checksum covers LEN, so 03+11+22+33 = 69.
    task automatic test_good_frame();
        logic [7:0] pl[$];
        logic [7:0] got;
        int cs, gc;
        pl = '{8'h11, 8'h22, 8'h33};
        clear_mon();
        send(8'hA5); send(8'h03);
        foreach (pl[k]) send(pl[k]);
        send(csum_of(3, pl)); cs = tx_cyc;
        idle(GAPC * 3 + 5);
        n_checks++; if (ov_byte.size() != 3) begin n_fail++; $display("FAIL good_count: got %0d want 3", ov_byte.size()); end
        for (int k = 0; k < 3; k++) begin
            got = (k < ov_byte.size()) ? ov_byte[k] : 8'hxx;
            gc  = (k < ov_cyc.size()) ? ov_cyc[k] : -1;
            n_checks++; if (got !== pl[k]) begin n_fail++; $display("FAIL good_byte%0d: got %h want %h", k, got, pl[k]); end
            n_checks++; if (gc != cs + 1 + GAPC * k) begin n_fail++; $display("FAIL good_time%0d: got %0d want %0d", k, gc, cs + 1 + GAPC * k); end
        end
        gc = (done_cyc.size() == 1) ? done_cyc[0] : -1;
        n_checks++; if (gc != cs + 1 + GAPC * 2 + 1) begin n_fail++; $display("FAIL good_done: got %0d want %0d", gc, cs + 2 + GAPC * 2); end
        n_checks++; if (err_cyc.size() != 0) begin n_fail++; $display("FAIL good_no_err: got %0d errs want 0", err_cyc.size()); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL good_busy: got %b want 0", busy); end
    endtask

    task automatic test_bad_csum();
        int cs;
        clear_mon();
        send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h6A); cs = tx_cyc;
        idle(GAPC * 3 + 5);
        exp_code = 3'd3;
        n_checks++; if (err_cyc.size() != 1 || err_cyc[0] != cs + 1) begin n_fail++; $display("FAIL csum_err_pulse: got %0d pulses want 1 at %0d", err_cyc.size(), cs + 1); end
        n_checks++; if (err_code !== exp_code) begin n_fail++; $display("FAIL csum_code: got %0d want %0d", err_code, exp_code); end
        n_checks++; if (ov_byte.size() != 0) begin n_fail++; $display("FAIL csum_no_out: got %0d bytes want 0", ov_byte.size()); end
        // Next good frame still goes through and does not clear the sticky code.
        clear_mon();
        send(8'hA5); send(8'h01); send(8'h7E); send(8'h7F);
        idle(GAPC + 5);
        n_checks++; if (ov_byte.size() != 1 || ov_byte[0] !== 8'h7E) begin n_fail++; $display("FAIL csum_recover: got %0d bytes want 1 byte 7e", ov_byte.size()); end
        n_checks++; if (done_cyc.size() != 1) begin n_fail++; $display("FAIL csum_recover_done: got %0d want 1", done_cyc.size()); end
        n_checks++; if (err_code !== exp_code) begin n_fail++; $display("FAIL csum_sticky: got %0d want %0d", err_code, exp_code); end
    endtask

    task automatic test_bad_len();
        logic [7:0] lens[2];
        int lc;
        lens[0] = 8'h00;
        lens[1] = 8'h21;
        for (int i = 0; i < 2; i++) begin
            clear_mon();
            send(8'hA5); send(lens[i]); lc = tx_cyc;
            idle(4);
            exp_code = 3'd1;
            n_checks++; if (err_cyc.size() != 1 || err_cyc[0] != lc + 1) begin n_fail++; $display("FAIL badlen_err_%h: got %0d pulses want 1 at %0d", lens[i], err_cyc.size(), lc + 1); end
            n_checks++; if (err_code !== exp_code) begin n_fail++; $display("FAIL badlen_code_%h: got %0d want 1", lens[i], err_code); end
            n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL badlen_idle_%h: got busy %b want 0", lens[i], busy); end
        end
    endtask

    task automatic test_timeout();
        int b;
        logic [7:0] pl[$];
        clear_mon();
        send(8'hA5); send(8'h04); send(8'h01); send(8'h02); b = tx_cyc;
        idle(TO + 5);
        exp_code = 3'd2;
        n_checks++; if (err_cyc.size() != 1 || err_cyc[0] != b + TO + 1) begin n_fail++; $display("FAIL timeout_err: got %0d pulses first %0d want 1 at %0d", err_cyc.size(), (err_cyc.size() > 0) ? err_cyc[0] : -1, b + TO + 1); end
        n_checks++; if (err_code !== exp_code) begin n_fail++; $display("FAIL timeout_code: got %0d want 2", err_code); end
        // Byte landing exactly on the limit cycle is still part of the frame.
        clear_mon();
        pl = '{8'h01, 8'h02, 8'h03, 8'h04};
        send(8'hA5); send(8'h04); send(pl[0]); send(pl[1]);
        idle(TO - 1);
        send(pl[2]); send(pl[3]); send(csum_of(4, pl));
        idle(GAPC * 4 + 5);
        n_checks++; if (err_cyc.size() != 0) begin n_fail++; $display("FAIL timeout_edge_err: got %0d errs want 0", err_cyc.size()); end
        n_checks++; if (ov_byte.size() != 4 || ov_byte[3] !== 8'h04) begin n_fail++; $display("FAIL timeout_edge_out: got %0d bytes want 4", ov_byte.size()); end
    endtask

    task automatic test_garbage();
        clear_mon();
        send(8'h00); send(8'hFF); send(8'h5A);
        send(8'hA5); send(8'h02); send(8'hAA); send(8'hBB); send(8'h67);
        idle(GAPC * 2 + 5);
        n_checks++; if (ov_byte.size() != 2 || ov_byte[0] !== 8'hAA || ov_byte[1] !== 8'hBB) begin n_fail++; $display("FAIL garbage_out: got %0d bytes want aa bb", ov_byte.size()); end
        n_checks++; if (err_cyc.size() != 0) begin n_fail++; $display("FAIL garbage_err: got %0d errs want 0", err_cyc.size()); end
        n_checks++; if (err_code !== exp_code) begin n_fail++; $display("FAIL garbage_code: got %0d want %0d", err_code, exp_code); end
    endtask

    task automatic test_line_err();
        int e;
        clear_mon();
        send(8'hA5); send(8'h04); send(8'h01);
        rx_error = 1'b1; rx_valid = 1'b1; rx_byte = 8'h02; e = cyc;
        @(negedge clk);
        rx_error = 1'b0; rx_valid = 1'b0;
        idle(4);
        exp_code = 3'd4;
        n_checks++; if (err_cyc.size() != 1 || err_cyc[0] != e + 1) begin n_fail++; $display("FAIL line_err_pulse: got %0d pulses want 1 at %0d", err_cyc.size(), e + 1); end
        n_checks++; if (err_code !== exp_code) begin n_fail++; $display("FAIL line_err_code: got %0d want 4", err_code); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL line_err_idle: got busy %b want 0", busy); end
    endtask

    task automatic test_overrun();
        int cs, o;
        clear_mon();
        send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h69); cs = tx_cyc;
        idle(1);
        send(8'h5A); o = tx_cyc;
        idle(GAPC * 3 + 5);
        exp_code = 3'd5;
        n_checks++; if (err_cyc.size() != 1 || err_cyc[0] != o + 1) begin n_fail++; $display("FAIL overrun_err: got %0d pulses want 1 at %0d", err_cyc.size(), o + 1); end
        n_checks++; if (err_code !== exp_code) begin n_fail++; $display("FAIL overrun_code: got %0d want 5", err_code); end
        n_checks++; if (ov_byte.size() != 3 || ov_byte[2] !== 8'h33 || ov_cyc[2] != cs + 1 + 2 * GAPC) begin n_fail++; $display("FAIL overrun_release: got %0d bytes want 3 ending 33 at %0d", ov_byte.size(), cs + 1 + 2 * GAPC); end
        n_checks++; if (done_cyc.size() != 1 || done_cyc[0] != cs + 2 + 2 * GAPC) begin n_fail++; $display("FAIL overrun_done: got %0d want 1 at %0d", done_cyc.size(), cs + 2 + 2 * GAPC); end
    endtask

    task automatic test_random();
        int kind, len, cs_cyc, l_cyc, gc;
        logic [7:0] pl[$];
        logic [7:0] cs, lb, got;
        for (int f = 0; f < 20; f++) begin
            kind = (f < 2) ? 2 : $urandom_range(0, 7);
            clear_mon();
            pl.delete();
            repeat ($urandom_range(0, 2)) begin
                do lb = 8'($urandom_range(0, 255)); while (lb == 8'hA5);
                send(lb);
                idle($urandom_range(0, 2));
            end
            if (kind == 1) begin
                lb = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAXB + 1, 255));
                send(8'hA5); idle($urandom_range(0, 2));
                send(lb); l_cyc = tx_cyc;
                idle(4);
                exp_code = 3'd1;
                n_checks++; if (err_cyc.size() != 1 || err_cyc[0] != l_cyc + 1) begin n_fail++; $display("FAIL rnd%0d_badlen: got %0d pulses want 1 at %0d", f, err_cyc.size(), l_cyc + 1); end
            end else begin
                len = (f == 0) ? MAXB : (f == 1) ? 1 : $urandom_range(1, MAXB);
                for (int k = 0; k < len; k++) pl.push_back(8'($urandom));
                cs = csum_of(len, pl);
                if (kind == 0) cs = cs + 8'($urandom_range(1, 255));
                send(8'hA5); idle($urandom_range(0, 2));
                send(8'(len));
                foreach (pl[k]) begin idle($urandom_range(0, 2)); send(pl[k]); end
                idle($urandom_range(0, 2));
                send(cs); cs_cyc = tx_cyc;
                idle(GAPC * len + 5);
                if (kind == 0) begin
                    exp_code = 3'd3;
                    n_checks++; if (err_cyc.size() != 1 || err_cyc[0] != cs_cyc + 1 || ov_byte.size() != 0) begin n_fail++; $display("FAIL rnd%0d_badcsum: got %0d errs %0d bytes want 1 err 0 bytes", f, err_cyc.size(), ov_byte.size()); end
                end else begin
                    n_checks++; if (err_cyc.size() != 0 || ov_byte.size() != len) begin n_fail++; $display("FAIL rnd%0d_good: got %0d errs %0d bytes want 0 errs %0d bytes", f, err_cyc.size(), ov_byte.size(), len); end
                    for (int k = 0; k < len; k++) begin
                        got = (k < ov_byte.size()) ? ov_byte[k] : 8'hxx;
                        gc  = (k < ov_cyc.size()) ? ov_cyc[k] : -1;
                        n_checks++; if (got !== pl[k] || gc != cs_cyc + 1 + GAPC * k) begin n_fail++; $display("FAIL rnd%0d_byte%0d: got %h at %0d want %h at %0d", f, k, got, gc, pl[k], cs_cyc + 1 + GAPC * k); end
                    end
                    gc = (done_cyc.size() == 1) ? done_cyc[0] : -1;
                    n_checks++; if (gc != cs_cyc + 1 + GAPC * (len - 1) + 1) begin n_fail++; $display("FAIL rnd%0d_done: got %0d want %0d", f, gc, cs_cyc + 1 + GAPC * (len - 1) + 1); end
                end
            end
            n_checks++; if (err_code !== exp_code) begin n_fail++; $display("FAIL rnd%0d_code: got %0d want %0d", f, err_code, exp_code); end
            n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_busy: got %b want 0", f, busy); end
        end
    endtask

    task automatic test_reset_mid_release();
        logic [7:0] pl[$];
        int seen;
        bit hit;
        pl = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        clear_mon();
        send(8'hA5); send(8'h05);
        foreach (pl[k]) send(pl[k]);
        send(csum_of(5, pl));
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(posedge clk); #1;
            if (out_valid && ov_byte.size() == 1) hit = 1'b1;
        end
        n_checks++; if (!hit) begin n_fail++; $display("FAIL rst_release_wait: second pulse not seen within 100 cycles, want seen"); end
        rst = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0 || out_byte !== 8'h00) begin n_fail++; $display("FAIL rst_release_out: got valid %b byte %h want 0 00", out_valid, out_byte); end
        n_checks++; if (busy !== 1'b0 || err_code !== 3'd0) begin n_fail++; $display("FAIL rst_release_state: got busy %b code %0d want 0 0", busy, err_code); end
        seen = ov_byte.size();
        idle(3);
        rst = 1'b1;
        idle(40);
        n_checks++; if (ov_byte.size() != seen || done_cyc.size() != 0) begin n_fail++; $display("FAIL rst_release_after: got %0d bytes %0d done want %0d bytes 0 done", ov_byte.size(), done_cyc.size(), seen); end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_csum();
        test_bad_len();
        test_timeout();
        test_garbage();
        test_line_err();
        test_overrun();
        test_random();
        test_reset_mid_release();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
